// File: rtl/seq_pkg.sv
// ============================================================================
// Module : seq_pkg
// Brief  : Shared types and control-word field indices for core_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam int CW_W = 18;

  localparam int BIT_CLK_HLT     = 17;
  localparam int BIT_REG_IN      = 16;
  localparam int BIT_RD_SEL_HI   = 15;
  localparam int BIT_RD_SEL_LO   = 14;
  localparam int BIT_REG_WE      = 13;
  localparam int BIT_MEM_WE      = 12;
  localparam int BIT_MEM_REQ     = 11;
  localparam int BIT_PC_IN       = 10;
  localparam int BIT_CSTACK_TYPE = 9;
  localparam int BIT_CSTACK_EXE  = 8;
  localparam int BIT_BRH         = 7;
  localparam int BIT_JMP         = 6;
  localparam int BIT_FLAGS_UPDT  = 5;
  localparam int BIT_ALU_HI      = 4;
  localparam int BIT_ALU_LO      = 0;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_t;

  function automatic logic is_mem_op(input logic [CW_W-1:0] cw);
    return cw[BIT_MEM_REQ] | cw[BIT_MEM_WE];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_if.sv
// ============================================================================
// Module : seq_if
// Brief  : Instruction and data memory req/ack handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_if;
  logic imem_req;
  logic imem_ack;
  logic ir_we;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req, ir_we, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, ir_we, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

`default_nettype wire

// File: rtl/seq_wdog.sv
// ============================================================================
// Module : seq_wdog
// Brief  : Memory wait counter; expires on the LIMIT-th wait cycle without ack.
//          Body is compiled only when SEQ_MEM_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef SEQ_MEM_TIMEOUT_EN
module seq_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of wait cycles already elapsed in this request
  assign expired = active && !ack && (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!active || ack || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
// Module : core_sequencer
// Brief  : BatPU2 multi-cycle control FSM; optional bus timeout via
//          SEQ_MEM_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module core_sequencer
  import seq_pkg::*;
#(
  parameter int CSTACK_DEPTH = 16,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_if.master           bus,
  input  logic [CW_W-1:0] ctr_word,
  input  logic            brh_cond,
  output logic            reg_we,
  output logic            flags_we,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            pc_sel,
  output logic            cs_push,
  output logic            cs_pop,
  output logic            retired,
  output logic            halted,
  output logic [1:0]      err
);

  localparam int DW = $clog2(CSTACK_DEPTH + 1);

  state_t            state;
  err_t              err_q;
  logic [DW-1:0]     depth;
  logic [CW_W-1:0]   cw_q;
  logic              imem_req_q;

  logic exec_fire, exec_halt, exec_ovf, exec_unf, exec_mem;
  logic mem_done, jump_taken, timeout;

  always_comb begin
    exec_fire = 1'b0;
    exec_halt = 1'b0;
    exec_ovf  = 1'b0;
    exec_unf  = 1'b0;
    exec_mem  = 1'b0;
    if (state == EXEC) begin
      if (cw_q[BIT_CLK_HLT])
        exec_halt = 1'b1;
      else if (cw_q[BIT_CSTACK_EXE] && !cw_q[BIT_CSTACK_TYPE] && depth == DW'(CSTACK_DEPTH))
        exec_ovf = 1'b1;
      else if (cw_q[BIT_CSTACK_EXE] && cw_q[BIT_CSTACK_TYPE] && depth == '0)
        exec_unf = 1'b1;
      else if (is_mem_op(cw_q))
        exec_mem = 1'b1;
      else
        exec_fire = 1'b1;
    end
  end

  assign mem_done   = (state == MEM) && bus.dmem_ack;
  assign jump_taken = cw_q[BIT_JMP] | (cw_q[BIT_BRH] & brh_cond);

  assign bus.imem_req = imem_req_q;
  assign bus.ir_we    = imem_req_q & bus.imem_ack;
  assign bus.dmem_req = (state == MEM);
  assign bus.dmem_we  = (state == MEM) & cw_q[BIT_MEM_WE];

  assign reg_we   = (exec_fire | mem_done) & cw_q[BIT_REG_WE];
  assign flags_we = exec_fire & cw_q[BIT_FLAGS_UPDT];
  assign pc_load  = exec_fire & jump_taken;
  assign pc_inc   = (exec_fire & !jump_taken) | mem_done;
  assign pc_sel   = (state == EXEC) & cw_q[BIT_PC_IN];
  assign cs_push  = exec_fire & cw_q[BIT_CSTACK_EXE] & !cw_q[BIT_CSTACK_TYPE];
  assign cs_pop   = exec_fire & cw_q[BIT_CSTACK_EXE] & cw_q[BIT_CSTACK_TYPE];
  assign retired  = exec_fire | mem_done;
  assign halted   = (state == HALT);
  assign err      = err_q;

`ifdef SEQ_MEM_TIMEOUT_EN
  seq_wdog #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (imem_req_q | (state == MEM)),
    .ack     (imem_req_q ? bus.imem_ack : bus.dmem_ack),
    .expired (timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = MEM_TIMEOUT;
  assign timeout            = 1'b0;
`endif

  logic [7:0] unused_cw_bits;
  assign unused_cw_bits = {cw_q[BIT_REG_IN], cw_q[BIT_RD_SEL_HI:BIT_RD_SEL_LO],
                           cw_q[BIT_ALU_HI:BIT_ALU_LO]};

  // imem_req is a flop, so the request never depends combinationally on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      err_q      <= ERR_NONE;
      depth      <= '0;
      cw_q       <= '0;
      imem_req_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req_q && bus.imem_ack) begin
            imem_req_q <= 1'b0;
            state      <= DECODE;
          end else if (timeout) begin
            imem_req_q <= 1'b0;
            err_q      <= ERR_TIMEOUT;
            state      <= HALT;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        DECODE: begin
          cw_q  <= ctr_word;
          state <= EXEC;
        end
        EXEC: begin
          if (exec_halt) begin
            state <= HALT;
          end else if (exec_ovf) begin
            err_q <= ERR_OVERFLOW;
            state <= HALT;
          end else if (exec_unf) begin
            err_q <= ERR_UNDERFLOW;
            state <= HALT;
          end else if (exec_mem) begin
            state <= MEM;
          end else begin
            if (cs_push)
              depth <= depth + DW'(1);
            else if (cs_pop)
              depth <= depth - DW'(1);
            imem_req_q <= 1'b1;
            state      <= FETCH;
          end
        end
        MEM: begin
          if (bus.dmem_ack) begin
            imem_req_q <= 1'b1;
            state      <= FETCH;
          end else if (timeout) begin
            err_q <= ERR_TIMEOUT;
            state <= HALT;
          end
        end
        HALT: state <= HALT;
        default: begin
          imem_req_q <= 1'b0;
          state      <= HALT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
